pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage. It replaces the fixed 16-bit PC register with a next-PC sequencer that handles sequential increment, stall, branch/exception redirect and halt. It also contains a small circular return-address stack (RAS) for call/return prediction. It feeds the instruction memory address and the PC+INC value into the IF/ID pipeline register.

---
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage next-PC sequencer. It handles sequential increment, stall, redirect and halt.
// It also holds a circular return-address stack that predicts call/return targets.
module pc_unit #(
    parameter int               WIDTH    = 16,
    parameter int               INC      = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             call,
    input  logic [WIDTH-1:0] call_target,
    input  logic             ret,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] ras_mem [DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_inc;
    logic [CW-1:0]    count;
    logic             push, replace, pop, uf_nxt;

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a);
        return a + WIDTH'(INC);
    endfunction

    assign pc_plus   = wrap_add(pc);
    assign top_inc   = top + 1'b1;
    assign halted    = (state == HALTED);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL_CNT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        replace   = 1'b0;
        pop       = 1'b0;
        uf_nxt    = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end else if (!stall) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else if (call && ret) begin
                        // Tail call: the new return address supersedes the top entry.
                        pc_nxt = call_target;
                        if (ras_empty) push = 1'b1;
                        else           replace = 1'b1;
                    end else if (call) begin
                        pc_nxt = call_target;
                        push   = 1'b1;
                    end else if (ret) begin
                        if (!ras_empty) begin
                            pc_nxt = ras_mem[top];
                            pop    = 1'b1;
                        end else begin
                            pc_nxt = pc_plus;
                            uf_nxt = 1'b1;
                        end
                    end else begin
                        pc_nxt = pc_plus;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            top           <= '0;
            count         <= '0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            ras_underflow <= uf_nxt;
            if (push) begin
                // A push while full overwrites the oldest entry, so count saturates.
                top <= top_inc;
                if (count != FULL_CNT) count <= count + 1'b1;
            end else if (pop) begin
                top   <= top - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push)         ras_mem[top_inc] <= pc_plus;
            else if (replace) ras_mem[top]     <= pc_plus;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit (WIDTH=16, INC=2, RESET_PC=0x0100, DEPTH=4).
module tb_pc_unit;

    typedef struct packed {
        logic        rv;
        logic [15:0] rpc;
        logic        st;
        logic        cl;
        logic [15:0] ct;
        logic        rt;
        logic        hl;
        logic        rs;
    } stim_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] pp;
        logic [3:0]  fl;   // halted, ras_empty, ras_full, ras_underflow
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        call = 1'b0;
    logic [15:0] call_target = '0;
    logic        ret = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc, pc_plus;
    logic        halted, ras_empty, ras_full, ras_underflow;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    pc_unit #(.WIDTH(16), .INC(2), .RESET_PC(16'h0100), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .call(call), .call_target(call_target), .ret(ret), .halt(halt),
        .pc(pc), .pc_plus(pc_plus), .halted(halted),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000 time units");
        $fatal(1, "bench timeout");
    end

    function automatic stim_t mk(input logic rv, input logic [15:0] rpc, input logic st,
                                 input logic cl, input logic [15:0] ct, input logic rt,
                                 input logic hl, input logic rs);
        stim_t s;
        s.rv = rv; s.rpc = rpc; s.st = st; s.cl = cl;
        s.ct = ct; s.rt = rt; s.hl = hl; s.rs = rs;
        return s;
    endfunction

    function automatic stim_t s_idle();
        return mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic stim_t s_rst();
        return mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic stim_t s_redir(input logic [15:0] p);
        return mk(1'b1, p, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic stim_t s_call(input logic [15:0] t);
        return mk(1'b0, 16'h0, 1'b0, 1'b1, t, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic stim_t s_ret();
        return mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic stim_t s_stall();
        return mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic obs_t ex(input logic [15:0] p, input logic h, input logic e,
                                input logic f, input logic u);
        obs_t o;
        o.pc = p;
        o.pp = p + 16'd2;
        o.fl = {h, e, f, u};
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pc = pc;
        o.pp = pc_plus;
        o.fl = {halted, ras_empty, ras_full, ras_underflow};
        return o;
    endfunction

    task automatic step(input stim_t s);
        rst            = s.rs;
        redirect_valid = s.rv;
        redirect_pc    = s.rpc;
        stall          = s.st;
        call           = s.cl;
        call_target    = s.ct;
        ret            = s.rt;
        halt           = s.hl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_rst());  x.push_back(ex(16'h0100, 0, 1, 0, 0));
        s.push_back(s_rst());  x.push_back(ex(16'h0100, 0, 1, 0, 0));
        s.push_back(s_idle()); x.push_back(ex(16'h0102, 0, 1, 0, 0));
        s.push_back(s_idle()); x.push_back(ex(16'h0104, 0, 1, 0, 0));
        s.push_back(s_idle()); x.push_back(ex(16'h0106, 0, 1, 0, 0));
        s.push_back(s_idle()); x.push_back(ex(16'h0108, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'hFFFE)); x.push_back(ex(16'hFFFE, 0, 1, 0, 0));
        s.push_back(s_idle());          x.push_back(ex(16'h0000, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'h0200)); x.push_back(ex(16'h0200, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            s.push_back(s_stall()); x.push_back(ex(16'h0200, 0, 1, 0, 0));
        end
        s.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 16'h0900, 1'b0, 1'b1, 1'b0));
        x.push_back(ex(16'h0200, 0, 1, 0, 0));
        s.push_back(mk(1'b1, 16'h0400, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
        x.push_back(ex(16'h0400, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_call_ret();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'h0010)); x.push_back(ex(16'h0010, 0, 1, 0, 0));
        s.push_back(s_call(16'h0100));  x.push_back(ex(16'h0100, 0, 0, 0, 0));
        s.push_back(s_call(16'h0200));  x.push_back(ex(16'h0200, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h0102, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h0012, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL callret[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_ras_overflow();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'h1000)); x.push_back(ex(16'h1000, 0, 1, 0, 0));
        s.push_back(s_call(16'h2000));  x.push_back(ex(16'h2000, 0, 0, 0, 0));
        s.push_back(s_call(16'h3000));  x.push_back(ex(16'h3000, 0, 0, 0, 0));
        s.push_back(s_call(16'h4000));  x.push_back(ex(16'h4000, 0, 0, 0, 0));
        s.push_back(s_call(16'h5000));  x.push_back(ex(16'h5000, 0, 0, 1, 0));
        s.push_back(s_call(16'h6000));  x.push_back(ex(16'h6000, 0, 0, 1, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h5002, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h4002, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h3002, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h2002, 0, 1, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h2004, 0, 1, 0, 1));
        s.push_back(s_idle());          x.push_back(ex(16'h2006, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL overflow[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_halt();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'h0300)); x.push_back(ex(16'h0300, 0, 1, 0, 0));
        s.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
        x.push_back(ex(16'h0300, 1, 1, 0, 0));
        for (int k = 0; k < 10; k++) begin
            s.push_back(mk(1'b0, 16'h0, k[2], ~k[0], 16'h0900, k[0], k[1], 1'b0));
            x.push_back(ex(16'h0300, 1, 1, 0, 0));
        end
        s.push_back(s_redir(16'h0500)); x.push_back(ex(16'h0500, 0, 1, 0, 0));
        s.push_back(s_idle());          x.push_back(ex(16'h0502, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halt[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_call_and_ret();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'h0050)); x.push_back(ex(16'h0050, 0, 1, 0, 0));
        s.push_back(s_call(16'h0080));  x.push_back(ex(16'h0080, 0, 0, 0, 0));
        s.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1, 16'h0700, 1'b1, 1'b0, 1'b0));
        x.push_back(ex(16'h0700, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h0082, 0, 1, 0, 0));
        s.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1, 16'h0800, 1'b1, 1'b0, 1'b0));
        x.push_back(ex(16'h0800, 0, 0, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h0084, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL callandret[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    task automatic test_mid_reset();
        stim_t s[$]; obs_t x[$]; obs_t got, want;
        s.push_back(s_redir(16'h0600)); x.push_back(ex(16'h0600, 0, 1, 0, 0));
        s.push_back(s_call(16'h0A00));  x.push_back(ex(16'h0A00, 0, 0, 0, 0));
        s.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
        x.push_back(ex(16'h0A00, 1, 0, 0, 0));
        s.push_back(mk(1'b1, 16'h0700, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1));
        x.push_back(ex(16'h0100, 0, 1, 0, 0));
        s.push_back(s_idle());          x.push_back(ex(16'h0102, 0, 1, 0, 0));
        s.push_back(s_stall());         x.push_back(ex(16'h0102, 0, 1, 0, 0));
        s.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1));
        x.push_back(ex(16'h0100, 0, 1, 0, 0));
        s.push_back(s_ret());           x.push_back(ex(16'h0102, 0, 1, 0, 1));
        s.push_back(s_rst());           x.push_back(ex(16'h0100, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]);
            step(s[i]);
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL midreset[%0d]: got pc=%h pc_plus=%h hefu=%b, want pc=%h pc_plus=%h hefu=%b",
                         i, got.pc, got.pp, got.fl, want.pc, want.pp, want.fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stall();
        test_call_ret();
        test_ras_overflow();
        test_halt();
        test_call_and_ret();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
